slot_game_ctrl: RTL and testbench

Parametrised slot-machine game controller, successor to the fixed three-reel game FSM. It takes coin and start inputs and keeps a saturating credit count. It spins N independent digit reels for a fixed duration, stops them one after another with a programmable gap, and pays out on a full match. Its outputs (credit, reel digits, status) feed the existing BCD/7-segment and text-LCD display path.

---
 rtl/slot_pkg.sv | 18 +
 rtl/slot_game_ctrl_if.sv | 46 ++++
 rtl/slot_reel.sv | 35 +++
 rtl/slot_game_ctrl.sv | 175 +++++++++++++++++
 tb/tb_slot_game_ctrl.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/slot_pkg.sv
// Shared types and constants for the slot-machine game controller.
package slot_pkg;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StReady    = 3'd1,
        StSpin     = 3'd2,
        StStopping = 3'd3,
        StEval     = 3'd4
    } state_t;

    typedef logic [3:0] digit_t;

    localparam digit_t      DigitWrap    = 4'd9;
    localparam digit_t      JackpotDigit = 4'd7;
    localparam int unsigned JackpotMult  = 5;

endpackage

// File: rtl/slot_game_ctrl_if.sv
// Player inputs and display-path outputs of slot_game_ctrl.
// The jackpot signal exists only when SLOT_JACKPOT_EN is defined.
interface slot_game_ctrl_if #(
    parameter int unsigned NUM_REELS = 3
);
    logic                     C_IN;
    logic                     GAME_START;
    logic [6:0]               credit;
    logic [4*NUM_REELS-1:0]   reel_digits;
    logic [NUM_REELS-1:0]     reel_stopped;
    logic                     spinning;
    logic                     win;
    logic [2:0]               state;
`ifdef SLOT_JACKPOT_EN
    logic                     jackpot;
`endif

    modport master (
        output C_IN,
        output GAME_START,
        input  credit,
        input  reel_digits,
        input  reel_stopped,
        input  spinning,
        input  win,
`ifdef SLOT_JACKPOT_EN
        input  jackpot,
`endif
        input  state
    );

    modport slave (
        input  C_IN,
        input  GAME_START,
        output credit,
        output reel_digits,
        output reel_stopped,
        output spinning,
        output win,
`ifdef SLOT_JACKPOT_EN
        output jackpot,
`endif
        output state
    );

endinterface

// File: rtl/slot_reel.sv
// One reel: free-running prescaler of period DIV and a mod-10 digit that
// advances on a prescaler tick only while i_run is high.
module slot_reel
    import slot_pkg::*;
#(
    parameter int unsigned DIV = 4
) (
    input  logic   i_clk,
    input  logic   i_rst_n,
    input  logic   i_run,
    output digit_t o_digit
);

    localparam int unsigned PreW = $clog2(DIV + 1);

    logic [PreW-1:0] r_pre;
    digit_t          r_digit;
    logic            w_tick;

    assign w_tick  = (r_pre == PreW'(DIV - 1));
    assign o_digit = r_digit;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pre   <= '0;
            r_digit <= '0;
        end else begin
            r_pre <= w_tick ? '0 : r_pre + PreW'(1);
            if (w_tick && i_run) begin
                r_digit <= (r_digit == DigitWrap) ? '0 : r_digit + 4'd1;
            end
        end
    end

endmodule

// File: rtl/slot_game_ctrl.sv
// Slot-machine game controller: coin/start edge detection, saturating credit,
// N spinning reels with staggered stops, payout on a full match.
// Optional SLOT_JACKPOT_EN: all-sevens pays JackpotMult*PAYOUT and drives jackpot.
module slot_game_ctrl
    import slot_pkg::*;
#(
    parameter int unsigned NUM_REELS   = 3,
    parameter int unsigned SPIN_CYCLES = 150,
    parameter int unsigned STOP_GAP    = 20,
    parameter int unsigned REEL_DIV    = 4,
    parameter int unsigned CREDIT_MAX  = 99,
    parameter int unsigned PAYOUT      = 10
) (
    input  logic             CLK,
    input  logic             RST,
    slot_game_ctrl_if.slave  bus
);

    localparam int unsigned SpinW = $clog2(SPIN_CYCLES + 1);
    localparam int unsigned GapW  = $clog2(STOP_GAP + 1);
    localparam logic [NUM_REELS-1:0] StopLsb = NUM_REELS'(1);

    state_t                 r_state;
    logic [6:0]             r_credit;
    logic                   r_coin_prev;
    logic                   r_start_prev;
    logic                   r_spinning;
    logic                   r_win;
    logic [SpinW-1:0]       r_spin_cnt;
    logic [GapW-1:0]        r_gap_cnt;
    logic [NUM_REELS-1:0]   r_stopped;

    logic [NUM_REELS-1:0]   w_run;
    digit_t                 w_digit [NUM_REELS];
    logic [4*NUM_REELS-1:0] w_digits_flat;
    logic                   w_coin_edge;
    logic                   w_start_edge;
    logic                   w_start_ok;
    logic                   w_match;
    logic [15:0]            w_pay;
    logic [15:0]            w_credit_sum;
    logic [6:0]             w_credit_next;
`ifdef SLOT_JACKPOT_EN
    logic                   r_jackpot;
    logic                   w_jack;
`endif

    for (genvar gi = 0; gi < NUM_REELS; gi++) begin : g_reel
        slot_reel #(
            .DIV (REEL_DIV + gi)
        ) u_reel (
            .i_clk   (CLK),
            .i_rst_n (RST),
            .i_run   (w_run[gi]),
            .o_digit (w_digit[gi])
        );
    end

    // A reel runs for all of SPIN and until its own stop bit rises in STOPPING.
    always_comb begin
        w_run         = '0;
        w_digits_flat = '0;
        w_match       = 1'b1;
        for (int i = 0; i < NUM_REELS; i++) begin
            w_run[i] = (r_state == StSpin) || ((r_state == StStopping) && !r_stopped[i]);
            w_digits_flat[4*i +: 4] = w_digit[i];
            if (w_digit[i] != w_digit[0]) begin
                w_match = 1'b0;
            end
        end
    end

`ifdef SLOT_JACKPOT_EN
    assign w_jack = w_match && (w_digit[0] == JackpotDigit);
`endif

    assign w_coin_edge  = bus.C_IN && !r_coin_prev;
    assign w_start_edge = bus.GAME_START && !r_start_prev;

    // Coin, payout and spend are folded into one sum so that simultaneous
    // events net out before saturation.
    always_comb begin
        w_pay = '0;
        if ((r_state == StEval) && w_match) begin
`ifdef SLOT_JACKPOT_EN
            w_pay = w_jack ? 16'(JackpotMult * PAYOUT) : 16'(PAYOUT);
`else
            w_pay = 16'(PAYOUT);
`endif
        end
        w_start_ok    = (r_state == StReady) && w_start_edge;
        w_credit_sum  = 16'(r_credit) + 16'(w_coin_edge) + w_pay - 16'(w_start_ok);
        w_credit_next = (w_credit_sum > 16'(CREDIT_MAX)) ? 7'(CREDIT_MAX) : 7'(w_credit_sum);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state      <= StIdle;
            r_credit     <= '0;
            r_coin_prev  <= 1'b0;
            r_start_prev <= 1'b0;
            r_spinning   <= 1'b0;
            r_win        <= 1'b0;
            r_spin_cnt   <= '0;
            r_gap_cnt    <= '0;
            r_stopped    <= '1;
`ifdef SLOT_JACKPOT_EN
            r_jackpot    <= 1'b0;
`endif
        end else begin
            r_coin_prev  <= bus.C_IN;
            r_start_prev <= bus.GAME_START;
            r_credit     <= w_credit_next;
            unique case (r_state)
                StIdle: begin
                    if (w_coin_edge) begin
                        r_state <= StReady;
                    end
                end
                StReady: begin
                    if (w_start_ok) begin
                        r_state    <= StSpin;
                        r_spinning <= 1'b1;
                        r_win      <= 1'b0;
`ifdef SLOT_JACKPOT_EN
                        r_jackpot  <= 1'b0;
`endif
                        r_spin_cnt <= '0;
                        r_stopped  <= '0;
                    end
                end
                StSpin: begin
                    if (r_spin_cnt == SpinW'(SPIN_CYCLES - 1)) begin
                        r_state   <= StStopping;
                        r_stopped <= StopLsb;
                        r_gap_cnt <= '0;
                    end else begin
                        r_spin_cnt <= r_spin_cnt + SpinW'(1);
                    end
                end
                StStopping: begin
                    // Stop bits fill from reel 0 upward, one every STOP_GAP cycles.
                    if (&r_stopped) begin
                        r_state    <= StEval;
                        r_spinning <= 1'b0;
                    end else if (r_gap_cnt == GapW'(STOP_GAP - 1)) begin
                        r_stopped <= (r_stopped << 1) | StopLsb;
                        r_gap_cnt <= '0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GapW'(1);
                    end
                end
                StEval: begin
                    r_win   <= w_match;
`ifdef SLOT_JACKPOT_EN
                    r_jackpot <= w_jack;
`endif
                    r_state <= (w_credit_next != '0) ? StReady : StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.credit       = r_credit;
    assign bus.reel_digits  = w_digits_flat;
    assign bus.reel_stopped = r_stopped;
    assign bus.spinning     = r_spinning;
    assign bus.win          = r_win;
    assign bus.state        = r_state;
`ifdef SLOT_JACKPOT_EN
    assign bus.jackpot      = r_jackpot;
`endif

endmodule

// File: tb/tb_slot_game_ctrl.sv
// Randomised bench for slot_game_ctrl: a 3-reel and a 1-reel instance share
// stimulus and are compared every cycle against a timeline-based game model.
module tb_slot_game_ctrl;

    localparam int S    = 150;
    localparam int G    = 20;
    localparam int DV   = 4;
    localparam int CMAX = 99;
    localparam int PAY  = 10;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic c_in = 1'b0;
    logic game_start = 1'b0;

    always #5 CLK = ~CLK;

    slot_game_ctrl_if #(.NUM_REELS(3)) bus0 ();
    slot_game_ctrl_if #(.NUM_REELS(1)) bus1 ();

    assign bus0.C_IN       = c_in;
    assign bus0.GAME_START = game_start;
    assign bus1.C_IN       = c_in;
    assign bus1.GAME_START = game_start;

    slot_game_ctrl #(.NUM_REELS(3)) u_dut0 (
        .CLK (CLK),
        .RST (RST),
        .bus (bus0)
    );

    slot_game_ctrl #(.NUM_REELS(1)) u_dut1 (
        .CLK (CLK),
        .RST (RST),
        .bus (bus1)
    );

    logic jk0, jk1;
`ifdef SLOT_JACKPOT_EN
    assign jk0 = bus0.jackpot;
    assign jk1 = bus1.jackpot;
`else
    assign jk0 = 1'b0;
    assign jk1 = 1'b0;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // Model: a game is a timeline measured from the edge that accepted it.
    int m_e;
    bit m_prev_c, m_prev_s;
    int m_credit [2];
    bit m_win    [2];
    bit m_jack   [2];
    bit m_active [2];
    int m_k      [2];
    int m_dig    [2][8];

    function automatic int nr(input int p);
        return (p == 0) ? 3 : 1;
    endfunction

    function automatic int game_len(input int p);
        return S + (nr(p) - 1) * G + 2;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_e = 0;
        m_prev_c = 1'b0;
        m_prev_s = 1'b0;
        for (int p = 0; p < 2; p++) begin
            m_credit[p] = 0;
            m_win[p]    = 1'b0;
            m_jack[p]   = 1'b0;
            m_active[p] = 1'b0;
            m_k[p]      = 0;
            for (int i = 0; i < 8; i++) m_dig[p][i] = 0;
        end
    endtask

    task automatic model_step(input bit c, input bit s);
        bit ce, se, sok, eq;
        int n, d, t, pay;
        ce = c && !m_prev_c;
        se = s && !m_prev_s;
        m_prev_c = c;
        m_prev_s = s;
        m_e++;
        n = m_e;
        for (int p = 0; p < 2; p++) begin
            pay = 0;
            sok = 1'b0;
            if (m_active[p]) begin
                d = n - m_k[p];
                for (int i = 0; i < nr(p); i++) begin
                    if (d >= 1 && d <= S + i * G && (n % (DV + i)) == 0)
                        m_dig[p][i] = (m_dig[p][i] + 1) % 10;
                end
                if (d == game_len(p)) begin
                    eq = 1'b1;
                    for (int i = 0; i < nr(p); i++)
                        if (m_dig[p][i] != m_dig[p][0]) eq = 1'b0;
                    m_win[p]  = eq;
                    m_jack[p] = 1'b0;
                    if (eq) pay = PAY;
`ifdef SLOT_JACKPOT_EN
                    if (eq && m_dig[p][0] == 7) begin
                        m_jack[p] = 1'b1;
                        pay = 5 * PAY;
                    end
`endif
                    m_active[p] = 1'b0;
                end
            end else if (m_credit[p] > 0 && se) begin
                sok = 1'b1;
            end
            t = m_credit[p] + int'(ce) + pay - int'(sok);
            m_credit[p] = (t > CMAX) ? CMAX : t;
            if (sok) begin
                m_win[p]    = 1'b0;
                m_jack[p]   = 1'b0;
                m_active[p] = 1'b1;
                m_k[p]      = n;
            end
        end
    endtask

    function automatic logic [63:0] pack(input logic [6:0] cr, input logic [2:0] st,
                                         input logic sp, input logic w, input logic j,
                                         input logic [7:0] stp, input logic [31:0] dg);
        return {11'b0, cr, st, sp, w, j, stp, dg};
    endfunction

    function automatic logic [63:0] expv(input int p);
        int d, st;
        logic [7:0]  stp;
        logic [31:0] dg;
        d  = m_e + 1 - m_k[p];
        st = (m_credit[p] > 0) ? 1 : 0;
        if (m_active[p]) st = (d <= S) ? 2 : ((d < game_len(p)) ? 3 : 4);
        stp = '0;
        dg  = '0;
        for (int i = 0; i < nr(p); i++) begin
            stp[i]     = !m_active[p] || (d >= S + 1 + i * G);
            dg[4*i+:4] = 4'(m_dig[p][i]);
        end
        return pack(7'(m_credit[p]), 3'(st), (st == 2 || st == 3), m_win[p], m_jack[p], stp, dg);
    endfunction

    function automatic logic [63:0] obsv(input int p);
        if (p == 0)
            return pack(bus0.credit, bus0.state, bus0.spinning, bus0.win, jk0,
                        8'(bus0.reel_stopped), 32'(bus0.reel_digits));
        return pack(bus1.credit, bus1.state, bus1.spinning, bus1.win, jk1,
                    8'(bus1.reel_stopped), 32'(bus1.reel_digits));
    endfunction

    task automatic compare_all(input string tag);
        check({tag, "/3reel"}, obsv(0), expv(0));
        check({tag, "/1reel"}, obsv(1), expv(1));
    endtask

    task automatic cycle(input bit c, input bit s);
        c_in = c;
        game_start = s;
        @(posedge CLK);
        model_step(c, s);
        @(negedge CLK);
        compare_all($sformatf("cyc%0d", m_e));
    endtask

    int k;

    initial begin
        model_reset();
        repeat (2) @(negedge CLK);
        compare_all("reset");
        RST = 1'b1;

        // start edges with zero credit are ignored
        cycle(1'b0, 1'b1); cycle(1'b0, 1'b0); cycle(1'b0, 1'b1); cycle(1'b0, 1'b0);
        check("idle_credit", 64'(bus0.credit), 64'd0);
        check("idle_state", 64'(bus0.state), 64'd0);

        repeat (3) begin cycle(1'b1, 1'b0); cycle(1'b0, 1'b0); end
        check("coins_credit", 64'(bus0.credit), 64'd3);
        check("coins_state", 64'(bus0.state), 64'd1);

        cycle(1'b0, 1'b1);
        k = m_e;
        check("start_credit", 64'(bus0.credit), 64'd2);
        check("start_spinning", 64'(bus0.spinning), 64'd1);
        check("start_state", 64'(bus0.state), 64'd2);

        for (int j = 1; j <= 200; j++) begin
            cycle(1'b0, (j % 37) == 5);
            if (m_e == k + 150) check("stop0", 64'(bus0.reel_stopped), 64'h1);
            if (m_e == k + 170) check("stop1", 64'(bus0.reel_stopped), 64'h3);
            if (m_e == k + 190) check("stop2", 64'(bus0.reel_stopped), 64'h7);
            if (m_e == k + 192) check("game_end_state", 64'(bus0.state), 64'd1);
            if (m_e == k + 192) check("game_end_credit", 64'(bus0.credit), 64'd2);
            if (m_e == k + 152) check("r1_win", 64'(bus1.win), 64'd1);
            if (m_e == k + 152) check("r1_pay", 64'(bus1.credit), 64'd12);
            if (m_e == k + 153) check("r1_win_clr", 64'(bus1.win), 64'd0);
        end

        for (int j = 0; j < 12000; j++)
            cycle(($urandom % 200) == 0, ($urandom % 12) == 0);

        repeat (105) begin cycle(1'b1, 1'b0); cycle(1'b0, 1'b0); end
        check("sat_credit0", 64'(bus0.credit), 64'd99);
        check("sat_credit1", 64'(bus1.credit), 64'd99);
        repeat (200) cycle(1'b0, 1'b0);

        // coin landing on the 1-reel EVAL edge together with a win
        cycle(1'b0, 1'b1);
        k = m_e;
        while (m_e < k + 151) cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0);
        check("eval_coin_credit", 64'(bus1.credit), 64'd99);
        check("eval_coin_win", 64'(bus1.win), 64'd1);

        while (m_e < k + 160) cycle(1'b0, 1'b0);
        check("pre_rst_state", 64'(bus0.state), 64'd3);
        RST = 1'b0;
        #1;
        model_reset();
        compare_all("async_rst");
        check("async_rst_stopped", 64'(bus0.reel_stopped), 64'h7);
        check("async_rst_credit", 64'(bus0.credit), 64'd0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;

        repeat (3) begin cycle(1'b1, 1'b0); cycle(1'b0, 1'b0); end
        cycle(1'b0, 1'b1);
        for (int j = 0; j < 400; j++) cycle(1'b0, ($urandom % 16) == 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
